sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO: next generation of the team's 16x8 synchronous FIFO, generalised in data width and depth. Adds programmable almost-full/almost-empty thresholds, an occupancy count, a read-valid strobe, and a selectable first-word-fall-through (FWFT) read mode. It is a drop-in buffer between any producer and consumer in the same clock domain, and it is the DUT of the next FIFO verification environment.

## Interface

Parameters:
- DATA_WIDTH, 16, word width in bits (≥1)
- DEPTH, 8, number of storage words (≥2; not required to be a power of two)
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read/pop request
- data_out  out  DATA_WIDTH  read data
- valid  out  1  data_out is valid (mode-dependent, see Operation)
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- wr_ack  out  1  registered pulse: previous-cycle write accepted
- overflow  out  1  registered pulse: previous-cycle write refused (full)
- underflow  out  1  registered pulse: previous-cycle read refused (empty)

## Operation

- Storage: DEPTH x DATA_WIDTH array, with wr_ptr and rd_ptr in 0..DEPTH-1. Each pointer wraps from DEPTH-1 to 0 explicitly; no modulo-2^n assumption.
- Accept rules, evaluated on pre-edge state:
  - write accepted = wr_en && (!full || rd_accept)
  - rd_accept = rd_en && !empty
- Accepted write: mem[wr_ptr] <= data_in, wr_ptr advances.
- Accepted read: rd_ptr advances.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous rd_en and wr_en:
  - When full: both accepted, count stays DEPTH, wr_ack=1, overflow=0.
  - When empty: write accepted, read refused, underflow=1.
- Status flags (full, empty, almost_full, almost_empty) are combinational decodes of the count register only, never of inputs.
- wr_ack, overflow, underflow:
  - Registered, high for exactly one cycle per request.
  - wr_ack and overflow are mutually exclusive.
- Standard mode (FWFT=0):
  - Accepted read registers mem[rd_ptr] into data_out and pulses valid for one cycle.
  - data_out holds its last value otherwise.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; valid = !empty.
  - rd_en acts as a pop acknowledging the presented word.
- Reset (rst=1 at edge):
  - Pointers and count go to 0; data_out (standard mode) goes to 0.
  - valid, wr_ack, overflow and underflow go to 0.
  - Resulting flags: empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not cleared.
  - Reset overrides any same-cycle wr_en/rd_en; those requests are dropped with no ack or error pulse.

## Timing

- Write to count/flag update: 1 cycle.
- Standard mode read latency: data_out and valid appear 1 cycle after the rd_en edge.
- FWFT mode: a word written into an empty FIFO appears on data_out with valid=1 one cycle after the write edge. A pop exposes the next word in the cycle after the popping edge.
- Status pulses appear in the cycle following the request edge.
- No combinational path from wr_en/rd_en to any output, except FWFT data_out/valid via the registered pointers.
- Full throughput: one write and one read per cycle sustained at any occupancy 1..DEPTH-1.

## Test plan

- Reset, then 8 writes of 0x0001..0x0008 (DEPTH=8, standard) -> wr_ack pulses each cycle; count 1..8; almost_full at count 7; full at 8; empty deasserts after the first write.
- 9th write while full, with rd_en=0 -> overflow=1 for one cycle, wr_ack=0, count stays 8. Then 8 reads -> data_out 0x0001..0x0008 in order, each with a one-cycle valid; empty after the last read.
- Read while empty -> underflow=1 for one cycle, valid=0, data_out unchanged. Simultaneous rd_en+wr_en(0xBEEF) while empty -> wr_ack=1, underflow=1, count=1.
- Simultaneous rd_en+wr_en while full -> wr_ack=1, overflow=0, count stays 8. Run 20 write/read cycles -> output order is preserved across pointer wrap; also repeat with DEPTH=6 to check non-power-of-two wrap.
- FWFT=1: write 0xA5A5 into empty FIFO -> next cycle data_out=0xA5A5, valid=1 with no rd_en. Pop -> valid=0 the cycle after.
- Assert rst mid-stream (count=5, wr_en=1) -> next cycle count=0, empty=1, no wr_ack. Then a write of 0x1234 followed by a read returns 0x1234.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, status pulses and optional first-word-fall-through reads.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         wr_ack,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          wr_ack_reg, overflow_reg, underflow_reg;
    logic          rd_accept, wr_accept;

    // Flags decode the registered count only, so inputs never reach them.
    assign count        = count_reg;
    assign full         = (count_reg == FULL_CNT);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_CNT);
    assign almost_empty = (count_reg <= AE_CNT);
    assign wr_ack       = wr_ack_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    always_comb begin
        rd_accept   = rd_en && !empty;
        // A full FIFO still takes a write when a read frees a slot in the same cycle.
        wr_accept   = wr_en && (!full || rd_accept);
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_accept) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PW'(1);
        end
        if (rd_accept) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PW'(1);
        end
        if (wr_accept && !rd_accept) begin
            count_next = count_reg + CW'(1);
        end else if (rd_accept && !wr_accept) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            wr_ack_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            wr_ack_reg    <= wr_accept;
            overflow_reg  <= wr_en && !wr_accept;
            underflow_reg <= rd_en && !rd_accept;
        end
    end

    // Storage is never cleared; reset only drops the same-cycle write.
    always_ff @(posedge clk) begin
        if (wr_accept && !rst) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rd_ptr_reg];
            assign valid    = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_out_reg;
            logic                  valid_reg;

            // Read-first on a full simultaneous read/write: the old word is returned.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out_reg <= '0;
                    valid_reg    <= 1'b0;
                end else begin
                    valid_reg <= rd_accept;
                    if (rd_accept) begin
                        data_out_reg <= mem[rd_ptr_reg];
                    end
                end
            end

            assign data_out = data_out_reg;
            assign valid    = valid_reg;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: three instances (depth 8 standard, depth 6 standard,
// depth 8 FWFT) share stimulus and are compared against a queue-based model.
module tb_sync_fifo_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] data_in = '0;

    logic [15:0] dout8, dout6, doutf;
    logic        valid8, valid6, validf;
    logic [3:0]  cnt8, cntf;
    logic [2:0]  cnt6;
    logic        full8, empty8, af8, ae8, ack8, ovf8, unf8;
    logic        full6, empty6, af6, ae6, ack6, ovf6, unf6;
    logic        fullf, emptyf, aff, aef, ackf, ovff, unff;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .FWFT(0)) dut8 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout8), .valid(valid8), .count(cnt8), .full(full8), .empty(empty8),
        .almost_full(af8), .almost_empty(ae8), .wr_ack(ack8), .overflow(ovf8),
        .underflow(unf8)
    );

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(6), .FWFT(0)) dut6 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout6), .valid(valid6), .count(cnt6), .full(full6), .empty(empty6),
        .almost_full(af6), .almost_empty(ae6), .wr_ack(ack6), .overflow(ovf6),
        .underflow(unf6)
    );

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .FWFT(1)) dutf (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(doutf), .valid(validf), .count(cntf), .full(fullf), .empty(emptyf),
        .almost_full(aff), .almost_empty(aef), .wr_ack(ackf), .overflow(ovff),
        .underflow(unff)
    );

    typedef logic [15:0] word_q_t [$];
    typedef struct packed {
        logic        ack;
        logic        ovf;
        logic        unf;
        logic        valid;
        logic [15:0] dout;
    } mstate_t;

    typedef struct {
        logic        w;
        logic        r;
        logic        rs;
        logic [15:0] d;
        int          cnt;
        logic [3:0]  flags;   // {full, empty, almost_full, almost_empty}
        logic [2:0]  pulses;  // {wr_ack, overflow, underflow}
        logic        valid;
        logic [15:0] dout;
    } vec_t;

    word_q_t q8, q6;
    mstate_t m8 = '0;
    mstate_t m6 = '0;
    vec_t    vecs [$];

    // Reference behaviour: an ordered list of stored words plus last-cycle outcome.
    task automatic model_step(ref word_q_t q, inout mstate_t m, input int dep);
        int n;
        bit ra, wa;
        if (rst) begin
            q.delete();
            m = '0;
        end else begin
            n  = q.size();
            ra = rd_en && (n > 0);
            wa = wr_en && ((n < dep) || ra);
            m.ack   = wa;
            m.ovf   = wr_en && !wa;
            m.unf   = rd_en && !ra;
            m.valid = ra;
            if (ra) m.dout = q.pop_front();
            if (wa) q.push_back(data_in);
        end
    endtask

    function automatic logic [3:0] exp_flags(input int n, input int dep);
        return {n == dep, n == 0, n >= dep - 1, n <= 1};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("d8_count",  32'(cnt8), q8.size());
        chk("d8_flags",  32'({full8, empty8, af8, ae8}), 32'(exp_flags(q8.size(), 8)));
        chk("d8_pulses", 32'({ack8, ovf8, unf8}), 32'({m8.ack, m8.ovf, m8.unf}));
        chk("d8_valid",  32'(valid8), 32'(m8.valid));
        chk("d8_dout",   32'(dout8), 32'(m8.dout));
        chk("d6_count",  32'(cnt6), q6.size());
        chk("d6_flags",  32'({full6, empty6, af6, ae6}), 32'(exp_flags(q6.size(), 6)));
        chk("d6_pulses", 32'({ack6, ovf6, unf6}), 32'({m6.ack, m6.ovf, m6.unf}));
        chk("d6_valid",  32'(valid6), 32'(m6.valid));
        chk("d6_dout",   32'(dout6), 32'(m6.dout));
        chk("fw_count",  32'(cntf), q8.size());
        chk("fw_flags",  32'({fullf, emptyf, aff, aef}), 32'(exp_flags(q8.size(), 8)));
        chk("fw_pulses", 32'({ackf, ovff, unff}), 32'({m8.ack, m8.ovf, m8.unf}));
        chk("fw_valid",  32'(validf), 32'(q8.size() > 0));
        if (q8.size() > 0) chk("fw_dout", 32'(doutf), 32'(q8[0]));
    endtask

    task automatic tick(input logic w, input logic r, input logic rs, input logic [15:0] d);
        wr_en   = w;
        rd_en   = r;
        rst     = rs;
        data_in = d;
        model_step(q8, m8, 8);
        model_step(q6, m6, 6);
        @(posedge clk);
        #1;
        check_all();
        $display("cyc w=%0d r=%0d rst=%0d d=%h | cnt8=%0d dout8=%h v8=%0d cnt6=%0d fwft=%h/%0d",
                 w, r, rs, d, cnt8, dout8, valid8, cnt6, doutf, validf);
    endtask

    function automatic vec_t mk(input logic w, input logic r, input logic rs,
                                input logic [15:0] d, input int cnt, input logic [2:0] pulses,
                                input logic v, input logic [15:0] dout);
        vec_t t;
        t.w = w; t.r = r; t.rs = rs; t.d = d; t.cnt = cnt;
        t.flags = exp_flags(cnt, 8);
        t.pulses = pulses; t.valid = v; t.dout = dout;
        return t;
    endfunction

    initial begin
        int unsigned wp;
        // Directed table for the depth-8 standard-mode instance.
        vecs.push_back(mk(0, 0, 1, 16'h0000, 0, 3'b000, 0, 16'h0000));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1, 0, 0, 16'(i), i, 3'b100, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 16'h0009, 8, 3'b010, 0, 16'h0000));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, 16'h0000, 8 - i, 3'b000, 1, 16'(i)));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 3'b001, 0, 16'h0008));
        vecs.push_back(mk(1, 1, 0, 16'hBEEF, 1, 3'b101, 0, 16'h0008));

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].w, vecs[i].r, vecs[i].rs, vecs[i].d);
            chk($sformatf("vec%0d_count", i),  32'(cnt8), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_flags", i),  32'({full8, empty8, af8, ae8}), 32'(vecs[i].flags));
            chk($sformatf("vec%0d_pulses", i), 32'({ack8, ovf8, unf8}), 32'(vecs[i].pulses));
            chk($sformatf("vec%0d_valid", i),  32'(valid8), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_dout", i),   32'(dout8), 32'(vecs[i].dout));
        end

        // Fill to full behind 0xBEEF, then simultaneous read and write while full.
        for (int i = 0; i < 7; i++) tick(1, 0, 0, 16'h0100 + 16'(i));
        chk("pre_full_count", 32'(cnt8), 32'd8);
        tick(1, 1, 0, 16'h0200);
        chk("full_rw_ack",   32'(ack8), 32'd1);
        chk("full_rw_ovf",   32'(ovf8), 32'd0);
        chk("full_rw_count", 32'(cnt8), 32'd8);
        chk("full_rw_dout",  32'(dout8), 32'hBEEF);

        // Sustained write+read across pointer wrap, then drain.
        for (int i = 0; i < 20; i++) tick(1, 1, 0, 16'h0300 + 16'(i));
        for (int i = 0; i < 9; i++) tick(0, 1, 0, 16'h0000);
        chk("drain_empty", 32'(empty8), 32'd1);

        // FWFT presentation and pop.
        tick(0, 0, 1, 16'h0000);
        tick(1, 0, 0, 16'hA5A5);
        chk("fwft_dout",  32'(doutf), 32'hA5A5);
        chk("fwft_valid", 32'(validf), 32'd1);
        tick(0, 1, 0, 16'h0000);
        chk("fwft_pop_valid", 32'(validf), 32'd0);

        // Reset mid-stream with a write pending.
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 16'h0010 + 16'(i));
        chk("mid_count", 32'(cnt8), 32'd5);
        tick(1, 0, 1, 16'h7777);
        chk("rst_count", 32'(cnt8), 32'd0);
        chk("rst_empty", 32'(empty8), 32'd1);
        chk("rst_ack",   32'(ack8), 32'd0);
        tick(1, 0, 0, 16'h1234);
        tick(0, 1, 0, 16'h0000);
        chk("post_rst_dout",  32'(dout8), 32'h1234);
        chk("post_rst_valid", 32'(valid8), 32'd1);

        // Randomized traffic with varying fill bias and rare resets.
        tick(0, 0, 1, 16'h0000);
        for (int ph = 0; ph < 4; ph++) begin
            wp = (ph == 0) ? 75 : (ph == 1) ? 50 : (ph == 2) ? 25 : 55;
            for (int i = 0; i < 150; i++) begin
                tick($urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp - 10,
                     $urandom_range(0, 199) == 0, 16'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
